branch_redirect_ctrl: RTL and testbench

Sequencer that turns a resolved branch/jump decision from the EX-stage branch unit into a PC redirect toward fetch. It latches the target, holds a redirect request until fetch accepts it, and flushes the wrong-path IF/ID slots. It stalls EX for the duration and keeps saturating branch statistics. It sits between the branch unit output (NextPCSrc) and the fetch/PC logic of the pipelined RV32I core.

---
 rtl/branch_redirect_ctrl_pkg.sv | 17 +
 rtl/branch_redirect_ctrl_sat_counter.sv | 35 +++
 rtl/branch_redirect_ctrl.sv | 127 ++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared control-path definitions for the RV32I pipeline: redirect FSM states
// and the BrOp bit positions agreed with the branch unit and decoder.
package rv_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } redir_state_t;

  localparam int BROP_JUMP_BIT   = 4;
  localparam int BROP_BRANCH_BIT = 3;

  // Drain counter holds at most FLUSH_CYCLES-1 = 3.
  localparam int DRAIN_W = 2;

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset and a synchronous
// clear that takes priority over an increment in the same cycle.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q = count_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Turns a resolved branch/jump from EX into a held PC redirect toward fetch,
// flushing wrong-path IF/ID slots and stalling EX until the redirect drains.
module branch_redirect_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ExValid,
  input  logic [4:0]       BrOp,
  input  logic             NextPCSrc,
  input  logic [XLEN-1:0]  TargetPC,
  input  logic             FetchReady,
  input  logic             ClrCount,
  output logic             RedirectValid,
  output logic [XLEN-1:0]  RedirectPC,
  output logic             FlushIF,
  output logic             FlushID,
  output logic             StallEX,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] TakenCount
);

  redir_state_t       state_q;
  logic [XLEN-1:0]    redirectPc_q;
  logic [DRAIN_W-1:0] drain_q;
  logic               redirectValid_q;
  logic               flushIf_q;
  logic               flushId_q;
  logic               stallEx_q;

  logic idleValid;
  logic brEvent;
  logic branchInc;
  logic takenInc;
  logic unusedBits;

  // The branch unit's taken flag alone defines a redirect, whatever BrOp says.
  assign idleValid = (state_q == IDLE) && ExValid;
  assign brEvent   = ExValid && NextPCSrc;
  assign branchInc = idleValid && BrOp[BROP_BRANCH_BIT];
  assign takenInc  = idleValid && NextPCSrc;

  assign unusedBits = ^{BrOp[BROP_JUMP_BIT], BrOp[2:0], TargetPC[0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      redirectPc_q    <= '0;
      drain_q         <= '0;
      redirectValid_q <= 1'b0;
      flushIf_q       <= 1'b0;
      flushId_q       <= 1'b0;
      stallEx_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (brEvent) begin
            state_q         <= REDIRECT;
            redirectPc_q    <= {TargetPC[XLEN-1:1], 1'b0};
            redirectValid_q <= 1'b1;
            flushIf_q       <= 1'b1;
            flushId_q       <= 1'b1;
            stallEx_q       <= 1'b1;
          end
        end
        REDIRECT: begin
          if (FetchReady) begin
            redirectValid_q <= 1'b0;
            flushIf_q       <= 1'b0;
            if (FLUSH_CYCLES > 1) begin
              state_q <= DRAIN;
              drain_q <= DRAIN_W'(FLUSH_CYCLES - 1);
            end else begin
              state_q   <= IDLE;
              flushId_q <= 1'b0;
              stallEx_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Leaving on the last count keeps DRAIN exactly FLUSH_CYCLES-1 long.
          drain_q <= drain_q - DRAIN_W'(1);
          if (drain_q <= DRAIN_W'(1)) begin
            state_q   <= IDLE;
            flushId_q <= 1'b0;
            stallEx_q <= 1'b0;
          end
        end
        default: begin
          state_q         <= IDLE;
          drain_q         <= '0;
          redirectValid_q <= 1'b0;
          flushIf_q       <= 1'b0;
          flushId_q       <= 1'b0;
          stallEx_q       <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_branchCount (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ClrCount),
    .inc   (branchInc),
    .q     (BranchCount)
  );

  sat_counter #(.W(CNT_W)) u_takenCount (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ClrCount),
    .inc   (takenInc),
    .q     (TakenCount)
  );

  assign RedirectValid = redirectValid_q;
  assign RedirectPC    = redirectPc_q;
  assign FlushIF       = flushIf_q;
  assign FlushID       = flushId_q;
  assign StallEX       = stallEx_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Cycle-by-cycle directed vectors for branch_redirect_ctrl, built with 4-bit
// counters so saturation is reachable quickly.
module tb_branch_redirect_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  typedef struct {
    string       name;
    logic        rstN;
    logic        exValid;
    logic [4:0]  brOp;
    logic        nextPcSrc;
    logic [31:0] targetPc;
    logic        fetchReady;
    logic        clrCount;
    logic        expRv;
    logic [31:0] expPc;
    logic        expFif;
    logic        expFid;
    logic        expStall;
    logic [3:0]  expBc;
    logic [3:0]  expTc;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ExValid;
  logic [4:0]       BrOp;
  logic             NextPCSrc;
  logic [XLEN-1:0]  TargetPC;
  logic             FetchReady;
  logic             ClrCount;
  logic             RedirectValid;
  logic [XLEN-1:0]  RedirectPC;
  logic             FlushIF;
  logic             FlushID;
  logic             StallEX;
  logic [CNT_W-1:0] BranchCount;
  logic [CNT_W-1:0] TakenCount;

  int   vecCount  = 0;
  int   missCount = 0;
  vec_t vecs[$];

  branch_redirect_ctrl #(
    .XLEN         (XLEN),
    .FLUSH_CYCLES (2),
    .CNT_W        (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ExValid       (ExValid),
    .BrOp          (BrOp),
    .NextPCSrc     (NextPCSrc),
    .TargetPC      (TargetPC),
    .FetchReady    (FetchReady),
    .ClrCount      (ClrCount),
    .RedirectValid (RedirectValid),
    .RedirectPC    (RedirectPC),
    .FlushIF       (FlushIF),
    .FlushID       (FlushID),
    .StallEX       (StallEX),
    .BranchCount   (BranchCount),
    .TakenCount    (TakenCount)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(input string n, input logic r, input logic ev,
                                 input logic [4:0] op, input logic nps,
                                 input logic [31:0] tgt, input logic fr,
                                 input logic clr, input logic rv,
                                 input logic [31:0] pc, input logic fif,
                                 input logic fid, input logic st,
                                 input logic [3:0] bc, input logic [3:0] tc);
    vec_t v;
    v.name = n;       v.rstN = r;        v.exValid = ev;  v.brOp = op;
    v.nextPcSrc = nps; v.targetPc = tgt; v.fetchReady = fr; v.clrCount = clr;
    v.expRv = rv;     v.expPc = pc;      v.expFif = fif;  v.expFid = fid;
    v.expStall = st;  v.expBc = bc;      v.expTc = tc;
    return v;
  endfunction

  task automatic checkOutput(input vec_t v);
    vecCount++;
    if ({RedirectValid, RedirectPC, FlushIF, FlushID, StallEX, BranchCount, TakenCount} !==
        {v.expRv, v.expPc, v.expFif, v.expFid, v.expStall, v.expBc, v.expTc}) begin
      missCount++;
      $display("[TB] FAIL %s (vec %0d): got rv=%b pc=%h fif=%b fid=%b st=%b bc=%0d tc=%0d, want rv=%b pc=%h fif=%b fid=%b st=%b bc=%0d tc=%0d",
               v.name, vecCount, RedirectValid, RedirectPC, FlushIF, FlushID, StallEX,
               BranchCount, TakenCount, v.expRv, v.expPc, v.expFif, v.expFid,
               v.expStall, v.expBc, v.expTc);
    end
  endtask

  // Inputs change on the falling edge; outputs are checked 1 ns after the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst_n      = v.rstN;
    ExValid    = v.exValid;
    BrOp       = v.brOp;
    NextPCSrc  = v.nextPcSrc;
    TargetPC   = v.targetPc;
    FetchReady = v.fetchReady;
    ClrCount   = v.clrCount;
    @(posedge clk);
    #1;
    checkOutput(v);
  endtask

  initial begin
    int bcExp;
    int tcExp;
    logic [31:0] pcExp;

    rst_n      = 1'b0;
    ExValid    = 1'b0;
    BrOp       = 5'b00000;
    NextPCSrc  = 1'b0;
    TargetPC   = '0;
    FetchReady = 1'b0;
    ClrCount   = 1'b0;

    vecs.push_back(mkVec("reset0", 0, 1, 5'b01000, 1, 32'h5555, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec("reset1", 0, 1, 5'b01000, 1, 32'h5555, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0));
    vecs.push_back(mkVec("beqTaken", 1, 1, 5'b01000, 1, 32'h1234, 1, 0, 1, 32'h1234, 1, 1, 1, 1, 1));
    vecs.push_back(mkVec("beqHandshake", 1, 0, 5'b00000, 0, 32'h0, 1, 0, 0, 32'h1234, 0, 1, 1, 1, 1));
    vecs.push_back(mkVec("beqDrainEnd", 1, 0, 5'b00000, 0, 32'h0, 0, 0, 0, 32'h1234, 0, 0, 0, 1, 1));
    vecs.push_back(mkVec("jalrOdd", 1, 1, 5'b10000, 1, 32'h2001, 0, 0, 1, 32'h2000, 1, 1, 1, 1, 2));
    vecs.push_back(mkVec("jalrWait1", 1, 0, 5'b00000, 0, 32'h0, 0, 0, 1, 32'h2000, 1, 1, 1, 1, 2));
    vecs.push_back(mkVec("ignoredEvent", 1, 1, 5'b01000, 1, 32'h3000, 0, 0, 1, 32'h2000, 1, 1, 1, 1, 2));
    vecs.push_back(mkVec("jalrWait3", 1, 0, 5'b00000, 0, 32'h0, 0, 0, 1, 32'h2000, 1, 1, 1, 1, 2));
    vecs.push_back(mkVec("jalrHandshake", 1, 0, 5'b00000, 0, 32'h0, 1, 0, 0, 32'h2000, 0, 1, 1, 1, 2));
    vecs.push_back(mkVec("drainIgnore", 1, 1, 5'b01000, 1, 32'h4000, 1, 0, 0, 32'h2000, 0, 0, 0, 1, 2));

    bcExp = 1;
    for (int i = 0; i < 10; i++) begin
      bcExp++;
      vecs.push_back(mkVec("notTaken", 1, 1, 5'b01001, 0, 32'h40, 0, 0, 0, 32'h2000, 0, 0, 0, 4'(bcExp), 2));
    end
    vecs.push_back(mkVec("noValid", 1, 0, 5'b01000, 1, 32'h50, 0, 0, 0, 32'h2000, 0, 0, 0, 11, 2));
    vecs.push_back(mkVec("plainNps", 1, 1, 5'b00000, 1, 32'h9, 1, 0, 1, 32'h8, 1, 1, 1, 11, 3));
    vecs.push_back(mkVec("plainHs", 1, 0, 5'b00000, 0, 32'h0, 1, 0, 0, 32'h8, 0, 1, 1, 11, 3));
    vecs.push_back(mkVec("plainEnd", 1, 0, 5'b00000, 0, 32'h0, 0, 0, 0, 32'h8, 0, 0, 0, 11, 3));

    for (int i = 0; i < 6; i++) begin
      bcExp = (bcExp < 15) ? bcExp + 1 : 15;
      vecs.push_back(mkVec("bcSaturate", 1, 1, 5'b01001, 0, 32'h60, 0, 0, 0, 32'h8, 0, 0, 0, 4'(bcExp), 3));
    end

    tcExp = 3;
    for (int j = 0; j < 20; j++) begin
      tcExp = (tcExp < 15) ? tcExp + 1 : 15;
      pcExp = (32'(j) << 8) | 32'h2;
      vecs.push_back(mkVec("jumpEvent", 1, 1, 5'b10000, 1, pcExp | 32'h1, 1, 0, 1, pcExp, 1, 1, 1, 15, 4'(tcExp)));
      vecs.push_back(mkVec("jumpHs", 1, 0, 5'b00000, 0, 32'h0, 1, 0, 0, pcExp, 0, 1, 1, 15, 4'(tcExp)));
      vecs.push_back(mkVec("jumpEnd", 1, 0, 5'b00000, 0, 32'h0, 1, 0, 0, pcExp, 0, 0, 0, 15, 4'(tcExp)));
    end

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Clear coinciding with a taken event: counters read 0, redirect still happens.
    applyStimulus(mkVec("clrWithEvent", 1, 1, 5'b01000, 1, 32'h81, 0, 1, 1, 32'h80, 1, 1, 1, 0, 0));
    applyStimulus(mkVec("clrHs", 1, 0, 5'b00000, 0, 32'h0, 1, 0, 0, 32'h80, 0, 1, 1, 0, 0));
    applyStimulus(mkVec("clrEnd", 1, 0, 5'b00000, 0, 32'h0, 0, 0, 0, 32'h80, 0, 0, 0, 0, 0));

    // Reset while waiting in REDIRECT: no handshake may complete.
    applyStimulus(mkVec("preReset", 1, 1, 5'b10000, 1, 32'h9000, 0, 0, 1, 32'h9000, 1, 1, 1, 0, 1));
    applyStimulus(mkVec("holdRedirect", 1, 0, 5'b00000, 0, 32'h0, 0, 0, 1, 32'h9000, 1, 1, 1, 0, 1));
    applyStimulus(mkVec("resetMid", 0, 0, 5'b00000, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0));
    applyStimulus(mkVec("afterReset", 1, 0, 5'b00000, 0, 32'h0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
